mac_requant: RTL and testbench

- Consumer end of the MAC array's partial-sum output (the co bus of the MAC cells).
- Accumulates a stream of signed CW+1-bit partial sums across K passes of one dot product, then adds bias, rounds, right-shifts, optionally applies ReLU and saturates to int8.
- Results leave through a valid/ready port feeding the activation buffer writer.

---
 rtl/mac_requant.sv | 76 +++++++
 tb/tb_mac_requant.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
// mac_requant: accumulates signed partial sums over K passes, then bias, round-half-up,
// arithmetic shift, optional ReLU and int8 saturation behind a p stage and an output register.
module mac_requant #(
  parameter int CW = 16,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [CW:0]   co_in,
  input  logic                 co_vld,
  input  logic                 co_last,
  output logic                 in_rdy,
  input  logic [4:0]           cfg_shift,
  input  logic signed [AW-1:0] cfg_bias,
  input  logic                 cfg_relu,
  output logic signed [7:0]    yo,
  output logic                 yo_sat,
  output logic                 yo_vld,
  input  logic                 yo_rdy
);
  logic signed [AW-1:0] r_acc, r_p_sum, w_ext, w_sum;
  logic                 r_open, r_p_vld, r_yo_vld, r_yo_sat;
  logic signed [7:0]    r_yo, w_yo;
  logic signed [AW+1:0] w_rnd, w_t, w_r, w_rr;
  logic                 w_acc, w_last, w_move, w_hi, w_lo;

  assign in_rdy = !r_p_vld || !r_yo_vld || yo_rdy;
  assign w_acc  = co_vld && in_rdy;
  assign w_last = w_acc && co_last;
  assign w_move = r_p_vld && (!r_yo_vld || yo_rdy);
  assign w_ext  = AW'(co_in);
  assign w_sum  = (r_open ? r_acc : '0) + w_ext;

  // Two guard bits keep p_sum + bias + rounding term exact before the shift.
  assign w_rnd = (cfg_shift == 5'd0) ? '0 : (AW+2)'(1) << (cfg_shift - 5'd1);
  assign w_t   = (AW+2)'(r_p_sum) + (AW+2)'(cfg_bias) + w_rnd;
  assign w_r   = w_t >>> cfg_shift;
  assign w_rr  = (cfg_relu && w_r[AW+1]) ? '0 : w_r;
  assign w_hi  = w_rr > (AW+2)'(127);
  assign w_lo  = w_rr < (AW+2)'(-128);
  assign w_yo  = w_hi ? 8'h7f : w_lo ? 8'h80 : w_rr[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_open   <= 1'b0;
      r_p_sum  <= '0;
      r_p_vld  <= 1'b0;
      r_yo     <= '0;
      r_yo_sat <= 1'b0;
      r_yo_vld <= 1'b0;
    end else begin
      if (w_acc) begin
        r_acc  <= co_last ? '0 : w_sum;
        r_open <= !co_last;
      end
      if (w_last) begin
        r_p_sum <= w_sum;
        r_p_vld <= 1'b1;
      end else if (w_move) begin
        r_p_vld <= 1'b0;
      end
      if (w_move) begin
        r_yo     <= w_yo;
        r_yo_sat <= w_hi || w_lo;
        r_yo_vld <= 1'b1;
      end else if (yo_rdy) begin
        r_yo_vld <= 1'b0;
      end
    end
  end

  assign yo     = r_yo;
  assign yo_sat = r_yo_sat;
  assign yo_vld = r_yo_vld;
endmodule

// File: tb/tb_mac_requant.sv
// tb_mac_requant: directed vector table and hand sequences, then randomized traffic
// against an arithmetic reference model with a result scoreboard.
module tb_mac_requant;
  localparam int CW = 16;
  localparam int AW = 24;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [CW:0]   co_in;
  logic                 co_vld, co_last, in_rdy;
  logic [4:0]           cfg_shift;
  logic signed [AW-1:0] cfg_bias;
  logic                 cfg_relu;
  logic signed [7:0]    yo;
  logic                 yo_sat, yo_vld, yo_rdy;

  typedef struct {int y; bit s;} res_t;
  typedef struct {int co; int bias; int sh; bit relu; int y; bit s;} vec_t;

  int     n_vec = 0;
  int     n_bad = 0;
  bit     mon_on = 1'b0;
  longint cur_sum = 0;
  res_t   exp_q[$];
  vec_t   tbl[$];

  always #5 clk = ~clk;

  mac_requant #(.CW(CW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .co_in(co_in), .co_vld(co_vld), .co_last(co_last),
    .in_rdy(in_rdy), .cfg_shift(cfg_shift), .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
    .yo(yo), .yo_sat(yo_sat), .yo_vld(yo_vld), .yo_rdy(yo_rdy)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Wrap the dot product to AW bits, then apply the requant rules with integer division.
  function automatic res_t model(input longint s, input longint bias, input int sh, input bit relu);
    longint w, t, d, r;
    res_t   o;
    w = s & ((64'sd1 <<< AW) - 1);
    if (w >= (64'sd1 <<< (AW - 1))) w -= (64'sd1 <<< AW);
    d = 64'sd1 <<< sh;
    t = w + bias + ((sh > 0) ? d / 2 : 0);
    r = (t >= 0) ? t / d : -((-t + d - 1) / d);
    if (relu && r < 0) r = 0;
    o.s = (r > 127) || (r < -128);
    o.y = int'((r > 127) ? 127 : (r < -128) ? -128 : r);
    return o;
  endfunction

  task automatic monitor;
    res_t e;
    if (!mon_on) return;
    chk("in_rdy", longint'(in_rdy), longint'((exp_q.size() < 2) || yo_rdy));
    if (yo_vld && yo_rdy) begin
      if (exp_q.size() == 0) chk("extra result", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rand yo", yo, e.y);
        chk("rand sat", longint'(yo_sat), longint'(e.s));
      end
    end
    if (co_vld && in_rdy) begin
      cur_sum += co_in;
      if (co_last) begin
        exp_q.push_back(model(cur_sum, cfg_bias, int'(cfg_shift), cfg_relu));
        cur_sum = 0;
      end
    end
  endtask

  task automatic tick;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (mon_on) yo_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic setcfg(input int sh, input longint b, input bit r);
    cfg_shift = 5'(sh);
    cfg_bias  = AW'(b);
    cfg_relu  = r;
  endtask

  task automatic send(input int v, input bit last, input int idle);
    int n;
    for (int i = 0; i < idle; i++) begin
      co_vld  = 1'b0;
      co_last = 1'($urandom);
      co_in   = 17'($urandom);
      tick();
    end
    co_in = 17'(v); co_last = last; co_vld = 1'b1; n = 0;
    while (!in_rdy && n < 300) begin tick(); n++; end
    if (n == 300) chk("accept timeout", 0, 1);
    tick();
    co_vld = 1'b0; co_last = 1'b0;
  endtask

  // Called one cycle after the last beat was accepted; yo_rdy must be high.
  task automatic expect_out(input string nm, input int y, input bit s);
    chk({nm, " early"}, longint'(yo_vld), 0);
    tick();
    chk({nm, " vld"}, longint'(yo_vld), 1);
    chk({nm, " yo"}, yo, y);
    chk({nm, " sat"}, longint'(yo_sat), longint'(s));
    tick();
  endtask

  initial begin
    int n, k;
    bit wrap;
    rst_n = 1'b0; co_vld = 1'b0; co_last = 1'b0; co_in = '0; yo_rdy = 1'b1;
    setcfg(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset yo", yo, 0);
    chk("reset sat", longint'(yo_sat), 0);
    chk("reset vld", longint'(yo_vld), 0);
    chk("reset in_rdy", longint'(in_rdy), 1);
    rst_n = 1'b1;
    tick();

    tbl.push_back('{300, 0, 2, 0, 75, 0});
    tbl.push_back('{40000, 0, 0, 0, 127, 1});
    tbl.push_back('{-40000, 0, 0, 0, -128, 1});
    tbl.push_back('{-40000, 0, 0, 1, 0, 0});
    tbl.push_back('{40000, 0, 0, 1, 127, 1});
    tbl.push_back('{-6, 0, 2, 0, -1, 0});
    tbl.push_back('{-7, 0, 2, 0, -2, 0});
    tbl.push_back('{-5, 0, 2, 0, -1, 0});
    tbl.push_back('{127, 0, 0, 0, 127, 0});
    tbl.push_back('{128, 0, 0, 0, 127, 1});
    tbl.push_back('{-128, 0, 0, 0, -128, 0});
    tbl.push_back('{-129, 0, 0, 0, -128, 1});
    tbl.push_back('{0, -1000, 3, 0, -125, 0});
    tbl.push_back('{65535, 8388607, 23, 0, 1, 0});
    tbl.push_back('{50, 0, 1, 1, 25, 0});
    tbl.push_back('{-3, 0, 1, 0, -1, 0});
    foreach (tbl[i]) begin
      setcfg(tbl[i].sh, tbl[i].bias, tbl[i].relu);
      send(tbl[i].co, 1'b1, 0);
      expect_out($sformatf("vec%0d", i), tbl[i].y, tbl[i].s);
    end

    setcfg(4, 6, 0);
    send(1000, 1'b0, 0);
    send(-200, 1'b0, 0);
    send(50, 1'b1, 0);
    expect_out("k3", 54, 0);
    setcfg(0, 0, 0);
    send(10, 1'b1, 0);
    expect_out("k3 cleared", 10, 0);

    yo_rdy = 1'b0;
    co_vld = 1'b1; co_last = 1'b1; co_in = 17'sd1;
    chk("bp rdy1", longint'(in_rdy), 1);
    tick();
    co_in = 17'sd2;
    chk("bp rdy2", longint'(in_rdy), 1);
    tick();
    co_in = 17'sd3;
    chk("bp stall", longint'(in_rdy), 0);
    tick(); tick();
    chk("bp stall hold", longint'(in_rdy), 0);
    chk("bp hold vld", longint'(yo_vld), 1);
    chk("bp hold yo", yo, 1);
    yo_rdy = 1'b1;
    #1;
    chk("bp release", longint'(in_rdy), 1);
    tick();
    co_vld = 1'b0; co_last = 1'b0;
    chk("bp vld2", longint'(yo_vld), 1);
    chk("bp yo2", yo, 2);
    tick();
    chk("bp vld3", longint'(yo_vld), 1);
    chk("bp yo3", yo, 3);
    tick();
    chk("bp empty", longint'(yo_vld), 0);

    yo_rdy = 1'b0;
    send(99, 1'b1, 0);
    send(500, 1'b0, 0);
    send(500, 1'b0, 0);
    tick();
    chk("pre-rst vld", longint'(yo_vld), 1);
    chk("pre-rst yo", yo, 99);
    rst_n = 1'b0;
    #1;
    chk("mid-rst yo", yo, 0);
    chk("mid-rst sat", longint'(yo_sat), 0);
    chk("mid-rst vld", longint'(yo_vld), 0);
    chk("mid-rst in_rdy", longint'(in_rdy), 1);
    tick();
    rst_n = 1'b1; yo_rdy = 1'b1;
    tick();
    send(7, 1'b1, 0);
    expect_out("post-rst", 7, 0);

    mon_on = 1'b1; cur_sum = 0;
    for (int p = 0; p < 10; p++) begin
      wrap = (p == 9);
      if (wrap) setcfg(16, 0, 0);
      else if (p == 8) setcfg(23, longint'($urandom_range(0, 16777215)) - 8388608, 1'($urandom));
      else setcfg(int'($urandom_range(0, 12)), longint'($urandom_range(0, 8191)) - 4096, 1'($urandom));
      for (int d = 0; d < (wrap ? 4 : 40); d++) begin
        k = wrap ? int'($urandom_range(200, 300)) : int'($urandom_range(1, 4));
        for (int b = 0; b < k; b++)
          send(wrap ? int'($urandom_range(40000, 65535)) : int'($urandom_range(0, 131071)) - 65536,
               b == k - 1, int'($urandom_range(0, 2)));
      end
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin tick(); n++; end
      if (exp_q.size() > 0) chk("drain timeout", exp_q.size(), 0);
    end
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
